rsc_viterbi_decoder: RTL and testbench

//  Hard-decision Viterbi decoder for the 8-state RSC constituent code produced by the encoder
//  (feedback 1+D^2+D^3, parity 1+D+D^3, 3-step trellis termination to state 0).

---
 rtl/rsc_pkg.sv | 38 +++
 rtl/rsc_acs_unit.sv | 30 +++
 rtl/rsc_viterbi_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_rsc_viterbi_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsc_pkg.sv
// Shared definitions for the 8-state RSC constituent code (feedback 1+D^2+D^3, parity 1+D+D^3).
// Used by the Viterbi decoder and by the bench encoder model.
// Trellis state index packs the shift register as {q0, q1, q2}, so the state-0 path is all-zero
// and the predecessors of next state {s,a,b} are {a,b,0} and {a,b,1}.
package rsc_pkg;

  localparam int unsigned N_STATES = 8;
  localparam int unsigned TAIL_LEN = 3;

  // Decoder FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_TAIL  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Feedback term f = q1 ^ q2
  function automatic logic fb(input logic [2:0] state);
    return state[1] ^ state[0];
  endfunction

  // s = u ^ f; next = (s, q0, q1)
  function automatic logic [2:0] next_state(input logic [2:0] state, input logic u);
    return {u ^ fb(state), state[2:1]};
  endfunction

  // z = s ^ q0 ^ q2
  function automatic logic exp_parity(input logic [2:0] state, input logic u);
    return u ^ fb(state) ^ state[2] ^ state[0];
  endfunction

  // Hamming distance of the received pair to the branch label (x = u, z = parity)
  function automatic logic [1:0] branch_metric(input logic [2:0] state, input logic u,
                                               input logic x, input logic z);
    return {1'b0, x ^ u} + {1'b0, z ^ exp_parity(state, u)};
  endfunction

endpackage

// File: rtl/rsc_acs_unit.sv
// Add-compare-select for one trellis state.
// Ports:
//   pm0_i / bm0_i : metric and branch metric via the predecessor with q2 = 0
//   pm1_i / bm1_i : metric and branch metric via the predecessor with q2 = 1
//   pm_o          : surviving metric
//   dec_o         : 1 when the q2 = 1 predecessor survives
// Purely combinational; the metric registers live in the decoder top.
module rsc_acs_unit #(
  parameter int unsigned PmW = 8
) (
  input  logic [PmW-1:0] pm0_i,
  input  logic [PmW-1:0] pm1_i,
  input  logic [1:0]     bm0_i,
  input  logic [1:0]     bm1_i,
  output logic [PmW-1:0] pm_o,
  output logic           dec_o
);

  logic [PmW-1:0] cand0, cand1, diff;

  always_comb begin
    cand0 = pm0_i + PmW'(bm0_i);
    cand1 = pm1_i + PmW'(bm1_i);
    // Sign of the modulo difference decides, so metric wrap-around is harmless; ties keep q2 = 0
    diff  = cand1 - cand0;
    dec_o = diff[PmW-1];
    pm_o  = dec_o ? cand1 : cand0;
  end

endmodule

// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the 8-state RSC constituent code with
// 3-step termination to state 0. Emits K decoded info bits per block, in order.
// Ports:
//   clk, aclr          : rising-edge clock, asynchronous active-high reset
//   start, K           : one-cycle block start pulse, block-size select sampled with it
//   in_valid, xk, zk   : one received (systematic, parity) hard-bit pair per valid cycle
//   dk, dk_valid       : decoded info bit and its qualifier
//   busy, done         : block in progress, one-cycle pulse after the last dk
//   pm_final           : state-0 metric after termination, held until the next done
module rsc_viterbi_decoder
  import rsc_pkg::*;
#(
  parameter int unsigned BLK_K0  = 1056,
  parameter int unsigned BLK_K1  = 6144,
  parameter int unsigned TB      = 32,
  parameter int unsigned PM_W    = 8,
  parameter int unsigned PM_INIT = 16
) (
  input  logic            clk,
  input  logic            aclr,
  input  logic            start,
  input  logic            K,
  input  logic            in_valid,
  input  logic            xk,
  input  logic            zk,
  output logic            dk,
  output logic            dk_valid,
  output logic            busy,
  output logic            done,
  output logic [PM_W-1:0] pm_final
);

  localparam int unsigned CNT_W = 13;
  localparam logic [CNT_W-1:0] LEN0_LAST  = CNT_W'(BLK_K0 - 1);
  localparam logic [CNT_W-1:0] LEN1_LAST  = CNT_W'(BLK_K1 - 1);
  localparam logic [CNT_W-1:0] DK_FIRST   = CNT_W'(TB - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(TB - 2);
  localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_LEN - 1);
  localparam logic [PM_W-1:0]  PM_START   = PM_W'(PM_INIT);

  logic [2:0]       state_q, state_d;
  logic             k_q, k_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] blk_last;
  logic [PM_W-1:0]  pm_q [N_STATES];
  logic [PM_W-1:0]  pm_d [N_STATES];
  logic [TB-1:0]    surv_q [N_STATES];
  logic [TB-1:0]    surv_d [N_STATES];
  logic             dk_q, dk_d;
  logic             dk_valid_q, dk_valid_d;
  logic             done_q, done_d;
  logic [PM_W-1:0]  pm_final_q, pm_final_d;

  logic [1:0]       bm0 [N_STATES];
  logic [1:0]       bm1 [N_STATES];
  logic [PM_W-1:0]  pm_acs [N_STATES];
  logic             dec [N_STATES];

  assign blk_last = k_q ? LEN1_LAST : LEN0_LAST;

  // Branch metrics into each next state from its two predecessors. With s = 0 these are also
  // the tail branches, so the same values serve DATA and TAIL.
  always_comb begin : p_bm
    logic [2:0] nx, p0, p1;
    nx = '0;
    p0 = '0;
    p1 = '0;
    for (int n = 0; n < N_STATES; n++) begin
      nx     = 3'(n);
      p0     = {nx[1:0], 1'b0};
      p1     = {nx[1:0], 1'b1};
      bm0[n] = branch_metric(p0, nx[2] ^ fb(p0), xk, zk);
      bm1[n] = branch_metric(p1, nx[2] ^ fb(p1), xk, zk);
    end
  end

  for (genvar g = 0; g < N_STATES; g++) begin : g_acs
    rsc_acs_unit #(
      .PmW (PM_W)
    ) u_acs (
      .pm0_i (pm_q[(g % 4) * 2]),
      .pm1_i (pm_q[(g % 4) * 2 + 1]),
      .bm0_i (bm0[g]),
      .bm1_i (bm1[g]),
      .pm_o  (pm_acs[g]),
      .dec_o (dec[g])
    );
  end

  always_comb begin : p_next
    logic [2:0]      nx, pred, best;
    logic [PM_W-1:0] diff;
    logic            u;
    state_d    = state_q;
    k_d        = k_q;
    sym_cnt_d  = sym_cnt_q;
    pm_d       = pm_q;
    surv_d     = surv_q;
    dk_d       = 1'b0;
    dk_valid_d = 1'b0;
    done_d     = 1'b0;
    pm_final_d = pm_final_q;
    nx         = '0;
    pred       = '0;
    best       = '0;
    diff       = '0;
    u          = 1'b0;

    if (start) begin
      // Opens a block from any state; an in-flight block is dropped without done
      state_d   = ST_DATA;
      k_d       = K;
      sym_cnt_d = '0;
      for (int n = 0; n < N_STATES; n++) begin
        pm_d[n]   = (n == 0) ? '0 : PM_START;
        surv_d[n] = '0;
      end
    end else begin
      case (state_q)
        ST_DATA, ST_TAIL: begin
          if (in_valid) begin
            for (int n = 0; n < N_STATES; n++) begin
              nx   = 3'(n);
              pred = {nx[1:0], dec[n]};
              u    = nx[2] ^ fb(pred);
              if (state_q == ST_DATA) begin
                pm_d[n]   = pm_acs[n];
                surv_d[n] = {surv_q[pred][TB-2:0], u};
              end else begin
                // s = 1 states are unreachable in the tail; keep them clearly losing
                pm_d[n]   = nx[2] ? pm_acs[n % 4] + PM_START : pm_acs[n];
                surv_d[n] = surv_q[pred];
              end
            end

            if (state_q == ST_DATA) begin
              // Minimum-metric state, lowest index on ties
              for (int i = 1; i < N_STATES; i++) begin
                diff = pm_d[i] - pm_d[best];
                if (diff[PM_W-1]) begin
                  best = 3'(i);
                end
              end
              dk_valid_d = (sym_cnt_q >= DK_FIRST);
              dk_d       = dk_valid_d & surv_d[best][TB-1];
              if (sym_cnt_q == blk_last) begin
                state_d   = ST_TAIL;
                sym_cnt_d = '0;
              end else begin
                sym_cnt_d = sym_cnt_q + CNT_W'(1);
              end
            end else begin
              if (sym_cnt_q == TAIL_LAST) begin
                state_d   = ST_FLUSH;
                sym_cnt_d = '0;
              end else begin
                sym_cnt_d = sym_cnt_q + CNT_W'(1);
              end
            end
          end
        end

        ST_FLUSH: begin
          // The oldest state-0 bit already left during DATA; drain the other TB-1
          dk_valid_d = 1'b1;
          dk_d       = surv_q[0][TB-2];
          surv_d[0]  = {surv_q[0][TB-2:0], 1'b0};
          if (sym_cnt_q == FLUSH_LAST) begin
            state_d = ST_DONE;
          end else begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          done_d     = 1'b1;
          pm_final_d = pm_q[0];
          state_d    = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q    <= ST_IDLE;
      k_q        <= 1'b0;
      sym_cnt_q  <= '0;
      dk_q       <= 1'b0;
      dk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      pm_final_q <= '0;
      for (int n = 0; n < N_STATES; n++) begin
        pm_q[n]   <= '0;
        surv_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sym_cnt_q  <= sym_cnt_d;
      dk_q       <= dk_d;
      dk_valid_q <= dk_valid_d;
      done_q     <= done_d;
      pm_final_q <= pm_final_d;
      for (int n = 0; n < N_STATES; n++) begin
        pm_q[n]   <= pm_d[n];
        surv_q[n] <= surv_d[n];
      end
    end
  end

  assign dk       = dk_q;
  assign dk_valid = dk_valid_q;
  assign done     = done_q;
  assign pm_final = pm_final_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rsc_viterbi_decoder.sv
// Bench for rsc_viterbi_decoder with a 16-bit block (K=1) and survivor depth 8.
// Expected output of a decodable block is simply the info word in order, and pm_final is the
// number of channel bit errors injected; a compare process checks every dk against that.
module tb_rsc_viterbi_decoder;
  import rsc_pkg::*;

  localparam int unsigned KLEN = 16;
  localparam int unsigned TBD  = 8;
  localparam int unsigned PMW  = 8;
  localparam int unsigned NSYM = KLEN + TAIL_LEN;

  logic           clk = 1'b0;
  logic           aclr, start, K, in_valid, xk, zk;
  logic           dk, dk_valid, busy, done;
  logic [PMW-1:0] pm_final;

  rsc_viterbi_decoder #(
    .BLK_K0  (1056),
    .BLK_K1  (KLEN),
    .TB      (TBD),
    .PM_W    (PMW),
    .PM_INIT (16)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .start    (start),
    .K        (K),
    .in_valid (in_valid),
    .xk       (xk),
    .zk       (zk),
    .dk       (dk),
    .dk_valid (dk_valid),
    .busy     (busy),
    .done     (done),
    .pm_final (pm_final)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [NSYM-1:0] enc_x, enc_z;
  logic [2:0]      enc_end;
  logic [KLEN-1:0] nxt_bits = '0;
  int              nxt_pm   = 0;

  logic            exp_q[$];
  int              exp_pm      = 0;
  int              dk_cnt      = 0;
  logic [KLEN-1:0] got_word    = '0;
  int              done_cnt    = 0;
  int              cyc         = 0;
  int              last_dk_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Encoder model: info bits LSB first, then three tail steps with u = feedback
  task automatic encode(input logic [KLEN-1:0] info);
    logic [2:0] st;
    logic       u;
    st = '0;
    for (int i = 0; i < int'(NSYM); i++) begin
      u        = (i < int'(KLEN)) ? info[i] : fb(st);
      enc_x[i] = u;
      enc_z[i] = exp_parity(st, u);
      st       = next_state(st, u);
    end
    enc_end = st;
  endtask

  // Start pulse with a corrupted symbol alongside, which must not be accepted
  task automatic begin_block(input logic [KLEN-1:0] info, input int nerr);
    encode(info);
    nxt_bits = info;
    nxt_pm   = nerr;
    start    = 1'b1;
    K        = 1'b1;
    in_valid = 1'b1;
    xk       = ~enc_x[0];
    zk       = ~enc_z[0];
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input int flip, input int max_gap);
    int g;
    for (int i = first; i <= last; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        xk       = 1'($urandom);
        zk       = 1'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      xk       = enc_x[i];
      zk       = enc_z[i] ^ (i == flip);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Bounded wait for the next done; optional noise on the inputs, which must be ignored
  task automatic wait_done(input int prev, input bit noise);
    int n;
    n = 0;
    while (done_cnt == prev && n < 200) begin
      if (noise) begin
        in_valid = 1'($urandom);
        xk       = 1'($urandom);
        zk       = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("done_seen", done_cnt, prev + 1);
  endtask

  // Compare process: sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (aclr) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0) check("busy_in_block", int'(busy), 1);
        if (dk_valid) begin
          if (exp_q.size() == 0) begin
            check("dk_unexpected", 1, 0);
          end else begin
            check("dk", int'(dk), int'(exp_q.pop_front()));
          end
          if (dk_cnt < int'(KLEN)) got_word[dk_cnt] = dk;
          dk_cnt++;
          last_dk_cyc = cyc;
        end
        if (done) begin
          check("done_latency", cyc - last_dk_cyc, 1);
          check("dk_count", dk_cnt, int'(KLEN));
          check("pm_final", int'(pm_final), exp_pm);
          check("busy_at_done", int'(busy), 0);
          done_cnt++;
        end
        if (start) begin
          exp_q.delete();
          for (int i = 0; i < int'(KLEN); i++) exp_q.push_back(nxt_bits[i]);
          exp_pm   = nxt_pm;
          dk_cnt   = 0;
          got_word = '0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    aclr     = 1'b1;
    start    = 1'b0;
    K        = 1'b0;
    in_valid = 1'b0;
    xk       = 1'b0;
    zk       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dk", int'(dk), 0);
    check("rst_dk_valid", int'(dk_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pm_final", int'(pm_final), 0);
    aclr = 1'b0;

    // Pin the encoder model against hand-worked values
    encode(16'h0000);
    check("model_zero_x", int'(enc_x), 0);
    check("model_zero_z", int'(enc_z), 0);
    encode(16'hA5C3);
    check("model_a5c3_x", int'(enc_x[7:0]), 'hC3);
    check("model_a5c3_z", int'(enc_z[7:0]), 'h91);
    check("model_a5c3_end", int'(enc_end), 0);

    // 1: all-zero block
    prev = done_cnt;
    begin_block(16'h0000, 0);
    feed(0, int'(NSYM) - 1, -1, 0);
    wait_done(prev, 1'b0);
    check("t1_word", int'(got_word), 0);
    check("t1_pm", int'(pm_final), 0);

    // 2: 16'hA5C3, clean channel
    prev = done_cnt;
    begin_block(16'hA5C3, 0);
    feed(0, int'(NSYM) - 1, -1, 0);
    wait_done(prev, 1'b0);
    check("t2_word", int'(got_word), 'hA5C3);
    check("t2_pm", int'(pm_final), 0);

    // 4: same block with random gaps and noise after the tail
    prev = done_cnt;
    begin_block(16'hA5C3, 0);
    feed(0, int'(NSYM) - 1, -1, 3);
    wait_done(prev, 1'b1);
    check("t4_word", int'(got_word), 'hA5C3);
    check("t4_pm", int'(pm_final), 0);

    // 3: one parity error at symbol 5
    prev = done_cnt;
    begin_block(16'hA5C3, 1);
    feed(0, int'(NSYM) - 1, 5, 0);
    wait_done(prev, 1'b0);
    check("t3_word", int'(got_word), 'hA5C3);
    check("t3_pm", int'(pm_final), 1);

    // 5: asynchronous reset at symbol 9 of DATA
    prev = done_cnt;
    begin_block(16'hA5C3, 0);
    feed(0, 8, -1, 0);
    in_valid = 1'b1;
    xk       = enc_x[9];
    zk       = enc_z[9];
    aclr     = 1'b1;
    #1;
    check("t5_dk", int'(dk), 0);
    check("t5_dk_valid", int'(dk_valid), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_pm_final", int'(pm_final), 0);
    @(posedge clk);
    #1;
    aclr     = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, prev);
    begin_block(16'h5A3C, 0);
    feed(0, int'(NSYM) - 1, -1, 0);
    wait_done(prev, 1'b0);
    check("t5_word", int'(got_word), 'h5A3C);

    // 6: abort during FLUSH of block 1, then block 2
    prev = done_cnt;
    begin_block(16'h1234, 0);
    feed(0, int'(NSYM) - 1, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    begin_block(16'h0F0F, 0);
    feed(0, int'(NSYM) - 1, -1, 0);
    wait_done(prev, 1'b0);
    check("t6_word", int'(got_word), 'h0F0F);
    repeat (20) @(posedge clk);
    #1;
    check("t6_single_done", done_cnt, prev + 1);
    check("t6_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
